sme_host: RTL

SME_HOST -- requirements
Module: sme_host

---
 rtl/sme_pkg.sv | 22 ++
 rtl/sme_char_buf.sv | 29 ++
 rtl/sme_host.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// Shared definitions for the string-matcher host: FSM encoding, buffer sizes,
// wait-timeout limit and the character constants used by the matcher protocol.
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_STR = 3'd1,
    ST_SEND_PAT = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int MAX_STR    = 32;
  localparam int MAX_PAT    = 8;
  localparam int WAIT_LIMIT = 64;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: one synchronous write port, one combinational read port,
// every slot refilled with FILL on reset.
module sme_char_buf #(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] FILL  = 8'h20
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= FILL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sme_host.sv
// Host side of the string matcher: streams the string and pattern buffers to
// the matcher, waits for its result (with timeout) and presents it as a pulse.
module sme_host
  import sme_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       str_we,
  input  logic [4:0] str_addr,
  input  logic       pat_we,
  input  logic [2:0] pat_addr,
  input  logic [7:0] wdata,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  state_t     r_state, w_nstate;
  logic [4:0] r_idx, w_nidx;
  logic [5:0] r_wcnt, w_nwcnt;
  logic [5:0] r_str_len, w_nstr_len, w_slen_c;
  logic [3:0] r_pat_len, w_npat_len, w_plen_c;
  logic       w_nmatch, w_ntimeout;
  logic [4:0] w_nindex;
  logic [7:0] w_nchar, w_str_rd, w_pat_rd;
  logic       w_str_we, w_pat_we;

  assign w_slen_c = (str_len > 6'(MAX_STR)) ? 6'(MAX_STR) : str_len;
  assign w_plen_c = (pat_len > 4'(MAX_PAT)) ? 4'(MAX_PAT) : pat_len;
  assign w_str_we = str_we & ~busy;
  assign w_pat_we = pat_we & ~busy;

  sme_char_buf #(.DEPTH(MAX_STR), .AW(5), .FILL(CH_SPACE)) u_str_buf (
    .i_clk(clk), .i_rst(reset), .i_we(w_str_we), .i_waddr(str_addr),
    .i_wdata(wdata), .i_raddr(w_nidx), .o_rdata(w_str_rd)
  );

  sme_char_buf #(.DEPTH(MAX_PAT), .AW(3), .FILL(CH_DOT)) u_pat_buf (
    .i_clk(clk), .i_rst(reset), .i_we(w_pat_we), .i_waddr(pat_addr),
    .i_wdata(wdata), .i_raddr(w_nidx[2:0]), .o_rdata(w_pat_rd)
  );

  always_comb begin
    w_nstate    = r_state;
    w_nidx      = r_idx;
    w_nwcnt     = r_wcnt;
    w_nstr_len  = r_str_len;
    w_npat_len  = r_pat_len;
    w_nmatch    = res_match;
    w_nindex    = res_index;
    w_ntimeout  = res_timeout;
    case (r_state)
      ST_IDLE: begin
        if (start && (pat_len != 4'd0)) begin
          w_nstr_len = w_slen_c;
          w_npat_len = w_plen_c;
          w_nidx     = 5'd0;
          w_nstate   = (send_str && (w_slen_c != 6'd0)) ? ST_SEND_STR : ST_SEND_PAT;
        end
      end
      ST_SEND_STR: begin
        if ({1'b0, r_idx} == r_str_len - 6'd1) begin
          w_nstate = ST_SEND_PAT;
          w_nidx   = 5'd0;
        end else begin
          w_nidx = r_idx + 5'd1;
        end
      end
      ST_SEND_PAT: begin
        if (r_idx == 5'(r_pat_len) - 5'd1) begin
          w_nstate = ST_WAIT;
          w_nidx   = 5'd0;
          w_nwcnt  = 6'd0;
        end else begin
          w_nidx = r_idx + 5'd1;
        end
      end
      ST_WAIT: begin
        // valid takes priority over the terminal count
        if (valid) begin
          w_nstate   = ST_DONE;
          w_nmatch   = match;
          w_nindex   = match_index;
          w_ntimeout = 1'b0;
        end else if (r_wcnt == 6'(WAIT_LIMIT - 1)) begin
          w_nstate   = ST_DONE;
          w_nmatch   = 1'b0;
          w_nindex   = 5'd0;
          w_ntimeout = 1'b1;
        end else begin
          w_nwcnt = r_wcnt + 6'd1;
        end
      end
      ST_DONE: w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  // A write landing on the same edge as acceptance is forwarded to the first character
  always_comb begin
    w_nchar = 8'h00;
    if (w_nstate == ST_SEND_STR)
      w_nchar = (w_str_we && (str_addr == w_nidx)) ? wdata : w_str_rd;
    else if (w_nstate == ST_SEND_PAT)
      w_nchar = (w_pat_we && (pat_addr == w_nidx[2:0])) ? wdata : w_pat_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 5'd0;
      r_wcnt      <= 6'd0;
      r_str_len   <= 6'd0;
      r_pat_len   <= 4'd0;
      chardata    <= 8'h00;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_timeout <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_idx       <= w_nidx;
      r_wcnt      <= w_nwcnt;
      r_str_len   <= w_nstr_len;
      r_pat_len   <= w_npat_len;
      chardata    <= w_nchar;
      isstring    <= (w_nstate == ST_SEND_STR);
      ispattern   <= (w_nstate == ST_SEND_PAT);
      busy        <= (w_nstate != ST_IDLE);
      res_valid   <= (w_nstate == ST_DONE);
      res_match   <= w_nmatch;
      res_index   <= w_nindex;
      res_timeout <= w_ntimeout;
    end
  end

endmodule
